// File: rtl/pool_ctrl_pkg.sv
// DRAM map, address packing and state encoding shared by the convolution and pooling controllers.
package pool_ctrl_pkg;

   localparam int unsigned OFMAP_BASE = 131072;
   localparam int unsigned POOL_BASE  = 196608;

   localparam int unsigned CH_W    = 4;
   localparam int unsigned Y_W     = 5;
   localparam int unsigned X_W     = 5;
   localparam int unsigned FIELD_W = CH_W + Y_W + X_W;

   localparam int unsigned ST_IDLE = 0;
   localparam int unsigned ST_RD   = 1;
   localparam int unsigned ST_FIN  = 2;
   localparam int unsigned ST_WR   = 3;
   localparam int unsigned ST_DONE = 4;

   typedef enum logic [4:0] {
      StIdle = 5'b00001,
      StRd   = 5'b00010,
      StFin  = 5'b00100,
      StWr   = 5'b01000,
      StDone = 5'b10000
   } pool_state_e;

   function automatic logic [FIELD_W-1:0] pack_addr(input logic [CH_W-1:0] c,
                                                    input logic [Y_W-1:0]  y,
                                                    input logic [X_W-1:0]  x);
      return {c, y, x};
   endfunction

endpackage

// File: rtl/pool_max_unit.sv
// Running signed maximum of one 2x2 window, with optional ReLU clamp on the output.
module pool_max_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          EN_RELU    = 1'b1
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic                  cmp_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] max_o
);

   logic [DATA_WIDTH-1:0] max_q, max_d;

   // Strict greater-than keeps the earlier sample on ties.
   always_comb begin
      max_d = max_q;
      if (clr_i) begin
         max_d = '0;
      end else if (load_i) begin
         max_d = data_i;
      end else if (cmp_i && ($signed(data_i) > $signed(max_q))) begin
         max_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!srstn) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_o = (EN_RELU && max_q[DATA_WIDTH-1]) ? '0 : max_q;

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 max-pooling controller: reads OFMAP windows from DRAM, writes pooled results to POOL region.
module pool_ctrl
   import pool_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 18,
   parameter bit          EN_RELU    = 1'b1
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  enable,
   input  logic [4:0]            num_chnl,
   input  logic [5:0]            fmap_height,
   input  logic [5:0]            fmap_width,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic                  dram_en_rd,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  dram_en_wr,
   output logic                  done
);

   pool_state_e state_q, state_d;
   logic [1:0]  k_q, k_d;
   logic [4:0]  c_q, c_d, py_q, py_d, px_q, px_d;
   logic [4:0]  nchnl_q, nchnl_d;
   logic [5:0]  height_q, height_d, width_q, width_d;

   logic [4:0]  ph, pw;
   logic        last_px, last_py, last_c;
   logic        max_clr, max_load, max_cmp;
   logic [DATA_WIDTH-1:0] max_val;
   logic [FIELD_W-1:0]    rd_field, wr_field;

   assign ph      = height_q[5:1];
   assign pw      = width_q[5:1];
   assign last_px = (px_q == pw - 5'd1);
   assign last_py = (py_q == ph - 5'd1);
   assign last_c  = (c_q == nchnl_q - 5'd1);

   // Tap k selects row 2py+k[1] and column 2px+k[0].
   assign rd_field = pack_addr(c_q[3:0], {py_q[3:0], k_q[1]}, {px_q[3:0], k_q[0]});
   assign wr_field = pack_addr(c_q[3:0], py_q, px_q);

   pool_max_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .EN_RELU    (EN_RELU)
   ) u_max (
      .clk    (clk),
      .srstn  (srstn),
      .clr_i  (max_clr),
      .load_i (max_load),
      .cmp_i  (max_cmp),
      .data_i (data_in),
      .max_o  (max_val)
   );

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      c_d        = c_q;
      py_d       = py_q;
      px_d       = px_q;
      nchnl_d    = nchnl_q;
      height_d   = height_q;
      width_d    = width_q;
      max_clr    = 1'b0;
      max_load   = 1'b0;
      max_cmp    = 1'b0;
      addr_in    = '0;
      dram_en_rd = 1'b0;
      addr_out   = '0;
      data_out   = '0;
      dram_en_wr = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            max_clr = 1'b1;
            if (enable) begin
               nchnl_d  = num_chnl;
               height_d = fmap_height;
               width_d  = fmap_width;
               k_d      = 2'd0;
               c_d      = 5'd0;
               py_d     = 5'd0;
               px_d     = 5'd0;
               if ((fmap_height[5:1] == 5'd0) || (fmap_width[5:1] == 5'd0) ||
                   (num_chnl == 5'd0)) begin
                  state_d = StDone;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            dram_en_rd = 1'b1;
            addr_in    = ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'(rd_field);
            // data_in lags the address by one cycle, so k=1 sees tap 0.
            max_load   = (k_q == 2'd1);
            max_cmp    = k_q[1];
            k_d        = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = StFin;
            end
         end
         StFin: begin
            max_cmp = 1'b1;
            state_d = StWr;
         end
         StWr: begin
            dram_en_wr = 1'b1;
            addr_out   = ADDR_WIDTH'(POOL_BASE) + ADDR_WIDTH'(wr_field);
            data_out   = max_val;
            state_d    = StRd;
            if (last_px) begin
               px_d = 5'd0;
               if (last_py) begin
                  py_d = 5'd0;
                  if (last_c) begin
                     c_d     = 5'd0;
                     state_d = StDone;
                  end else begin
                     c_d = c_q + 5'd1;
                  end
               end else begin
                  py_d = py_q + 5'd1;
               end
            end else begin
               px_d = px_q + 5'd1;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!srstn) begin
         state_q  <= StIdle;
         k_q      <= 2'd0;
         c_q      <= 5'd0;
         py_q     <= 5'd0;
         px_q     <= 5'd0;
         nchnl_q  <= 5'd0;
         height_q <= 6'd0;
         width_q  <= 6'd0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         c_q      <= c_d;
         py_q     <= py_d;
         px_q     <= px_d;
         nchnl_q  <= nchnl_d;
         height_q <= height_d;
         width_q  <= width_d;
      end
   end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl with a 1-cycle-latency DRAM model; ReLU on and off instances.
module tb_pool_ctrl;

   localparam int DW = 32;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          srstn = 1'b0;
   logic          enable = 1'b0;
   logic [4:0]    num_chnl = '0;
   logic [5:0]    fmap_height = '0;
   logic [5:0]    fmap_width = '0;
   logic [DW-1:0] data_in = '0;

   logic [AW-1:0] addr_in, addr_out, addr_in_nr, addr_out_nr;
   logic [DW-1:0] data_out, data_out_nr;
   logic          en_rd, en_wr, done, en_rd_nr, en_wr_nr, done_nr;

   pool_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EN_RELU(1'b1)) dut (
      .clk(clk), .srstn(srstn), .enable(enable), .num_chnl(num_chnl),
      .fmap_height(fmap_height), .fmap_width(fmap_width), .data_in(data_in),
      .addr_in(addr_in), .dram_en_rd(en_rd), .addr_out(addr_out), .data_out(data_out),
      .dram_en_wr(en_wr), .done(done)
   );

   pool_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EN_RELU(1'b0)) dut_nr (
      .clk(clk), .srstn(srstn), .enable(enable), .num_chnl(num_chnl),
      .fmap_height(fmap_height), .fmap_width(fmap_width), .data_in(data_in),
      .addr_in(addr_in_nr), .dram_en_rd(en_rd_nr), .addr_out(addr_out_nr),
      .data_out(data_out_nr), .dram_en_wr(en_wr_nr), .done(done_nr)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:16383];
   int cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (en_rd) data_in <= mem[addr_in[13:0]];
   end

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] wa[$];
   logic [AW-1:0] ra[$];
   logic [DW-1:0] wd[$];
   logic [DW-1:0] wdn[$];
   int done_at;
   bit stray, overlap, timed_out;
   logic          s_rd, s_wr, s_done;
   logic [AW-1:0] s_ai, s_ao;
   logic [DW-1:0] s_do;

   task automatic clear_mem();
      for (int i = 0; i < 16384; i++) mem[i] = '0;
   endtask

   task automatic fill_basic();
      clear_mem();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) mem[y*32 + x] = DW'(y*4 + x);
   endtask

   // One start pulse, then observe each cycle at the falling edge until done (or reset + 1).
   task automatic run(input logic [4:0] nch, input logic [5:0] h, input logic [5:0] w,
                      input int poke_at, input int rst_at, input int budget);
      int t0, rel;
      wa.delete(); wd.delete(); wdn.delete(); ra.delete();
      done_at = -1; stray = 0; overlap = 0; timed_out = 0;
      @(negedge clk);
      num_chnl = nch; fmap_height = h; fmap_width = w; enable = 1'b1;
      t0 = cyc;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         rel = cyc - t0;
         enable = 1'b0; num_chnl = nch; fmap_height = h; fmap_width = w; srstn = 1'b1;
         if (en_rd) ra.push_back(addr_in);
         else if (addr_in != '0) stray = 1;
         if (en_wr) begin
            wa.push_back(addr_out); wd.push_back(data_out); wdn.push_back(data_out_nr);
         end else if (addr_out != '0 || data_out != '0) stray = 1;
         if (en_rd && en_wr) overlap = 1;
         if ({en_rd_nr, en_wr_nr, done_nr, addr_in_nr, addr_out_nr} !=
             {en_rd, en_wr, done, addr_in, addr_out}) stray = 1;
         if (rst_at >= 0 && rel == rst_at + 1) begin
            s_rd = en_rd; s_wr = en_wr; s_done = done; s_ai = addr_in; s_ao = addr_out;
            s_do = data_out;
            return;
         end
         if (done) begin
            done_at = rel;
            return;
         end
         if (rel == rst_at) srstn = 1'b0;
         if (rel == poke_at) begin
            enable = 1'b1; num_chnl = 5'd2; fmap_height = 6'd8; fmap_width = 6'd8;
         end
      end
      timed_out = 1;
   endtask

   task automatic test_reset();
      srstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({en_rd, en_wr, done} !== 3'b000) begin
         errors++; $display("FAIL reset_enables got=%b want=000", {en_rd, en_wr, done});
      end
      checks++;
      if (addr_in !== '0 || addr_out !== '0) begin
         errors++; $display("FAIL reset_addr got=%h/%h want=0/0", addr_in, addr_out);
      end
      checks++;
      if (data_out !== '0 || data_out_nr !== '0) begin
         errors++; $display("FAIL reset_data got=%h/%h want=0/0", data_out, data_out_nr);
      end
      srstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({en_rd, en_wr, done} !== 3'b000) begin
         errors++; $display("FAIL idle_after_reset got=%b want=000", {en_rd, en_wr, done});
      end
   endtask

   task automatic check_basic_writes(input string tag);
      logic [AW-1:0] ea [4] = '{18'd196608, 18'd196609, 18'd196640, 18'd196641};
      logic [DW-1:0] ed [4] = '{32'd5, 32'd7, 32'd13, 32'd15};
      checks++;
      if (timed_out || done_at != 25) begin
         errors++; $display("FAIL %s_done_cycle got=%0d want=25", tag, done_at);
      end
      checks++;
      if (wa.size() != 4) begin
         errors++; $display("FAIL %s_write_count got=%0d want=4", tag, wa.size());
      end
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         checks++;
         if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
            errors++;
            $display("FAIL %s_write%0d got=%0d@%0d want=%0d@%0d", tag, i, wd[i], wa[i],
                     ed[i], ea[i]);
         end
      end
   endtask

   task automatic test_basic();
      logic [AW-1:0] er [4] = '{18'd131072, 18'd131073, 18'd131104, 18'd131105};
      fill_basic();
      run(5'd1, 6'd4, 6'd4, -1, -1, 200);
      check_basic_writes("basic");
      checks++;
      if (ra.size() != 16) begin
         errors++; $display("FAIL basic_read_count got=%0d want=16", ra.size());
      end
      for (int i = 0; i < 4 && i < ra.size(); i++) begin
         checks++;
         if (ra[i] !== er[i]) begin
            errors++; $display("FAIL basic_tap%0d got=%0d want=%0d", i, ra[i], er[i]);
         end
      end
      checks++;
      if (stray || overlap) begin
         errors++; $display("FAIL basic_idle_outputs got=%0d/%0d want=0/0", stray, overlap);
      end
   endtask

   task automatic test_relu();
      clear_mem();
      mem[0] = -32'sd5; mem[1] = -32'sd3; mem[32] = -32'sd8; mem[33] = -32'sd9;
      run(5'd1, 6'd2, 6'd2, -1, -1, 100);
      checks++;
      if (timed_out || done_at != 7 || wa.size() != 1) begin
         errors++; $display("FAIL relu_run got=%0d,%0d want=7,1", done_at, wa.size());
      end
      if (wa.size() == 1) begin
         checks++;
         if (wd[0] !== 32'd0 || wa[0] !== 18'd196608) begin
            errors++; $display("FAIL relu_on got=%0d@%0d want=0@196608", wd[0], wa[0]);
         end
         checks++;
         if (wdn[0] !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL relu_off got=%h want=fffffffd", wdn[0]);
         end
      end
   endtask

   task automatic test_odd_multi();
      logic [AW-1:0] ea [4] = '{18'd196608, 18'd196640, 18'd197632, 18'd197664};
      logic [DW-1:0] ed [4] = '{32'd11, 32'd31, 32'd111, 32'd131};
      bit bad;
      clear_mem();
      for (int c = 0; c < 2; c++)
         for (int y = 0; y < 5; y++)
            for (int x = 0; x < 3; x++)
               mem[c*1024 + y*32 + x] = (y == 4 || x == 2) ? 32'd1000 : DW'(c*100 + y*10 + x);
      run(5'd2, 6'd5, 6'd3, -1, -1, 200);
      checks++;
      if (timed_out || done_at != 25 || wa.size() != 4) begin
         errors++; $display("FAIL odd_run got=%0d,%0d want=25,4", done_at, wa.size());
      end
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         checks++;
         if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
            errors++;
            $display("FAIL odd_write%0d got=%0d@%0d want=%0d@%0d", i, wd[i], wa[i], ed[i], ea[i]);
         end
      end
      bad = 0;
      foreach (ra[i]) if (ra[i][9:5] == 5'd4 || ra[i][4:0] == 5'd2 || ra[i][17:14] != 4'd8) bad = 1;
      checks++;
      if (bad || ra.size() != 16) begin
         errors++; $display("FAIL odd_reads got=%0d,%0d want=0,16", bad, ra.size());
      end
   endtask

   task automatic test_degenerate();
      run(5'd1, 6'd4, 6'd1, -1, -1, 50);
      checks++;
      if (timed_out || done_at != 1 || ra.size() != 0 || wa.size() != 0) begin
         errors++;
         $display("FAIL degen_width got=%0d,%0d,%0d want=1,0,0", done_at, ra.size(), wa.size());
      end
      run(5'd0, 6'd4, 6'd4, -1, -1, 50);
      checks++;
      if (timed_out || done_at != 1 || ra.size() != 0 || wa.size() != 0) begin
         errors++;
         $display("FAIL degen_chnl got=%0d,%0d,%0d want=1,0,0", done_at, ra.size(), wa.size());
      end
   endtask

   task automatic test_reset_mid_run();
      fill_basic();
      run(5'd1, 6'd4, 6'd4, -1, 17, 100);
      checks++;
      if ({s_rd, s_wr, s_done} !== 3'b000 || s_ai !== '0 || s_ao !== '0 || s_do !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got=%b,%h,%h,%h want=000,0,0,0",
                  {s_rd, s_wr, s_done}, s_ai, s_ao, s_do);
      end
      checks++;
      if (wa.size() != 2) begin
         errors++; $display("FAIL midreset_writes got=%0d want=2", wa.size());
      end
      run(5'd1, 6'd4, 6'd4, -1, -1, 200);
      check_basic_writes("restart");
   endtask

   task automatic test_enable_busy();
      fill_basic();
      run(5'd1, 6'd4, 6'd4, 2, -1, 200);
      check_basic_writes("busy");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_odd_multi();
      test_degenerate();
      test_reset_mid_run();
      test_enable_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
